// File: rtl/spi_master_ctrl.sv
// Frame-level SPI master: 11-bit MOSI frames, optional 8-bit MISO read-back.
// Optional read-sequence checker enabled with `define SPI_MASTER_SEQCHK_EN.
module spi_master_ctrl #(
  parameter int TURN_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_payload,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
`ifdef SPI_MASTER_SEQCHK_EN
  output logic       seq_err,
`endif
  output logic       rd_valid,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_TURN  = 3'd2;
  localparam logic [2:0] S_RECV  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] frame_q, frame_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  rdat_q, rdat_d;
  logic        rvld_q, rvld_d;
  logic        ss_q, ss_d;
  logic        mosi_q, mosi_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic        accept;

  assign accept = cmd_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    is_rd_d = is_rd_q;
    cap_d   = cap_q;
    rdat_d  = rdat_q;
    rvld_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          frame_d = {cmd_type[1], cmd_type, cmd_payload};
          is_rd_d = (cmd_type == 2'b11);
          state_d = S_SHIFT;
          cnt_d   = 4'd10;
        end
      end
      S_SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (is_rd_q) begin
            state_d = S_TURN;
            cnt_d   = 4'(TURN_CYCLES - 1);
          end else begin
            state_d = S_GAP;
            cnt_d   = 4'(GAP_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RECV;
          cnt_d   = 4'd7;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECV: begin
        cap_d = {cap_q[6:0], MISO};
        if (cnt_q == 4'd0) begin
          rdat_d  = {cap_q[6:0], MISO};
          rvld_d  = 1'b1;
          state_d = S_GAP;
          cnt_d   = 4'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Output flops are loaded from next state so they track state_q.
    ss_d   = !((state_d == S_SHIFT) || (state_d == S_TURN) ||
               (state_d == S_RECV));
    mosi_d = (state_d == S_SHIFT) && frame_d[cnt_d];
    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      frame_q <= 11'd0;
      is_rd_q <= 1'b0;
      cap_q   <= 8'd0;
      rdat_q  <= 8'd0;
      rvld_q  <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      is_rd_q <= is_rd_d;
      cap_q   <= cap_d;
      rdat_q  <= rdat_d;
      rvld_q  <= rvld_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign SS_n      = ss_q;
  assign MOSI      = mosi_q;
  assign rd_data   = rdat_q;
  assign rd_valid  = rvld_q;
  assign busy      = busy_q;

`ifdef SPI_MASTER_SEQCHK_EN
  logic armed_q, armed_d;
  logic serr_q, serr_d;

  always_comb begin
    armed_d = armed_q;
    serr_d  = 1'b0;
    if (accept && (cmd_type == 2'b10)) begin
      armed_d = 1'b1;
    end
    if (accept && (cmd_type == 2'b11)) begin
      armed_d = 1'b0;
      serr_d  = !armed_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      serr_q  <= serr_d;
    end
  end

  assign seq_err = serr_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with TURN_CYCLES=1, GAP_CYCLES=1.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_payload;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
`ifdef SPI_MASTER_SEQCHK_EN
  logic       seq_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.TURN_CYCLES(1), .GAP_CYCLES(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_type    (cmd_type),
    .cmd_payload (cmd_payload),
    .SS_n        (SS_n),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .rd_data     (rd_data),
`ifdef SPI_MASTER_SEQCHK_EN
    .seq_err     (seq_err),
`endif
    .rd_valid    (rd_valid),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [10:0] obs,
                     input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_timeout"}, 11'(cmd_ready), 11'd1);
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] p);
    @(negedge clk);
    wait_ready("send");
    cmd_valid   = 1'b1;
    cmd_type    = t;
    cmd_payload = p;
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [10:0] f);
    logic [10:0] ss_bad;
    logic [10:0] mo;
    ss_bad = '0;
    mo     = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ss_bad[10-i] = SS_n;
      mo[10-i]     = MOSI;
    end
    chk({tag, "_ss_low"}, ss_bad, 11'd0);
    chk({tag, "_mosi"}, mo, f);
  endtask

  logic [7:0] miso_bits;
  int         cnt;

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_type    = 2'b00;
    cmd_payload = 8'h00;
    MISO        = 1'b0;
    #2;
    chk("rst_ss", 11'(SS_n), 11'd1);
    chk("rst_mosi", 11'(MOSI), 11'd0);
    chk("rst_ready", 11'(cmd_ready), 11'd0);
    chk("rst_rd_data", 11'(rd_data), 11'd0);
    chk("rst_busy", 11'(busy), 11'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready0", 11'(cmd_ready), 11'd0);
    @(posedge clk);
    #1;
    chk("rel_ready1", 11'(cmd_ready), 11'd1);

    // WR_ADDR 0xA5
    send(2'b00, 8'hA5);
    chk("wa_busy", 11'(busy), 11'd1);
    chk("wa_ready", 11'(cmd_ready), 11'd0);
    check_frame("wa", 11'b000_1010_0101);
    @(negedge clk);
    chk("wa_gap_ss", 11'(SS_n), 11'd1);
    chk("wa_gap_ready", 11'(cmd_ready), 11'd0);
    @(negedge clk);
    chk("wa_idle_ready", 11'(cmd_ready), 11'd1);
    chk("wa_idle_busy", 11'(busy), 11'd0);

    // RD_DATA 0x00, slave returns 0x3C
    miso_bits = 8'h3C;
    MISO = 1'b1;
    send(2'b11, 8'h00);
    check_frame("rd", 11'b111_0000_0000);
    @(negedge clk);
    chk("rd_turn_ss", 11'(SS_n), 11'd0);
    chk("rd_turn_mosi", 11'(MOSI), 11'd0);
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (SS_n !== 1'b0) cnt++;
      if (rd_valid !== 1'b0) cnt++;
      MISO = miso_bits[7-j];
    end
    chk("rd_recv_ss_low_no_valid", 11'(cnt), 11'd0);
    @(negedge clk);
    MISO = 1'b1;
    chk("rd_end_ss", 11'(SS_n), 11'd1);
    chk("rd_valid_pulse", 11'(rd_valid), 11'd1);
    chk("rd_data", 11'(rd_data), 11'h03C);
    @(negedge clk);
    chk("rd_valid_drop", 11'(rd_valid), 11'd0);
    chk("rd_data_hold", 11'(rd_data), 11'h03C);
    chk("rd_idle_ready", 11'(cmd_ready), 11'd1);

    // back-to-back WR_DATA 0xFF then RD_ADDR 0x12
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_type    = 2'b01;
    cmd_payload = 8'hFF;
    @(posedge clk);
    #1;
    cmd_type    = 2'b10;
    cmd_payload = 8'h12;
    check_frame("b2b1", 11'b001_1111_1111);
    @(negedge clk);
    chk("b2b_gap_ss", 11'(SS_n), 11'd1);
    chk("b2b_gap_ready", 11'(cmd_ready), 11'd0);
    @(negedge clk);
    chk("b2b_idle_ss", 11'(SS_n), 11'd1);
    chk("b2b_idle_ready", 11'(cmd_ready), 11'd1);
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    cmd_payload = 8'h00;
    check_frame("b2b2", 11'b110_0001_0010);
    @(negedge clk);
    chk("b2b2_gap_ss", 11'(SS_n), 11'd1);
    chk("b2b_rd_data_keep", 11'(rd_data), 11'h03C);

    // reset during SHIFT bit 5 of RD_DATA 0xFF
    send(2'b11, 8'hFF);
    for (int i = 0; i < 5; i++) @(negedge clk);
    @(negedge clk);
    chk("mid_bit5", 11'(MOSI), 11'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ss", 11'(SS_n), 11'd1);
    chk("mid_rst_mosi", 11'(MOSI), 11'd0);
    chk("mid_rst_rd_data", 11'(rd_data), 11'd0);
    chk("mid_rst_busy", 11'(busy), 11'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_valid !== 1'b0) cnt++;
      if (SS_n !== 1'b1) cnt++;
    end
    chk("mid_no_activity", 11'(cnt), 11'd0);
    send(2'b00, 8'h5A);
    check_frame("post", 11'b000_0101_1010);
    @(negedge clk);
    chk("post_gap_ss", 11'(SS_n), 11'd1);

`ifdef SPI_MASTER_SEQCHK_EN
    send(2'b11, 8'h01);
    chk("seq_err_pulse", 11'(seq_err), 11'd1);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (seq_err !== 1'b0) cnt++;
    end
    chk("seq_err_once", 11'(cnt), 11'd0);
    send(2'b10, 8'h02);
    chk("seq_addr_ok", 11'(seq_err), 11'd0);
    send(2'b11, 8'h03);
    chk("seq_data_ok", 11'(seq_err), 11'd0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (seq_err !== 1'b0) cnt++;
    end
    chk("seq_quiet", 11'(cnt), 11'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
